// File: rtl/wb_addr_decode_fsm.sv
// wb_addr_decode_fsm: registered Wishbone address decoder/router, one master to
// SLAVE_NUM slaves. Each slave owns a window [START_k, END_k) of the upper
// ADDR_PERFIX address bits; the lowest-index slave wins on overlap. The block adds
// a no-hit error, a per-access timeout, abort on cyc drop and error-address capture.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   m_cyc_i/stb_i/we_i    master handshake
//   m_adr_i/dat_i/sel_i   master address, write data, byte select
//   m_dat_o               read data, held between responses
//   m_ack_o, m_err_o      one-cycle response pulses
//   s_cyc_o, s_stb_o      one-hot strobes to the selected slave (ACCESS only)
//   s_we_o/adr_o/dat_o/sel_o  registered request, shared by all slaves
//   s_dat_i               packed slave read data, slave k at [k*DW +: DW]
//   s_ack_i, s_err_i      slave responses (only the selected slave is heard)
//   err_addr_o            address of the most recent failed access
//   err_flag_o            sticky error flag, err_clr_i clears it (clear wins)
module wb_addr_decode_fsm #(
  parameter int SLAVE_NUM   = 4,
  parameter int ADDR_PERFIX = 8,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter logic [SLAVE_NUM*ADDR_PERFIX-1:0] START_ADDRS = {8'h42, 8'h41, 8'h40, 8'h00},
  parameter logic [SLAVE_NUM*ADDR_PERFIX-1:0] END_ADDRS   = {8'h43, 8'h42, 8'h41, 8'h40},
  parameter int TIMEOUT     = 255,
  localparam int SELW       = DW / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m_cyc_i,
  input  logic                    m_stb_i,
  input  logic                    m_we_i,
  input  logic [AW-1:0]           m_adr_i,
  input  logic [DW-1:0]           m_dat_i,
  input  logic [SELW-1:0]         m_sel_i,
  output logic [DW-1:0]           m_dat_o,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic [SLAVE_NUM-1:0]    s_cyc_o,
  output logic [SLAVE_NUM-1:0]    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [SELW-1:0]         s_sel_o,
  input  logic [SLAVE_NUM*DW-1:0] s_dat_i,
  input  logic [SLAVE_NUM-1:0]    s_ack_i,
  input  logic [SLAVE_NUM-1:0]    s_err_i,
  output logic [AW-1:0]           err_addr_o,
  output logic                    err_flag_o,
  input  logic                    err_clr_i
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [SELW-1:0] sel;
  } req_t;

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  logic [SLAVE_NUM-1:0] sel_q, sel_d, hit_sel;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        rdat_q, rdat_d, slv_rdat;
  logic [AW-1:0]        err_addr_q, err_addr_d;
  logic                 err_flag_q, err_flag_d;
  logic [ADDR_PERFIX-1:0] prefix;
  logic                 ack_hit, err_hit, timeout_hit;

  assign prefix = m_adr_i[AW-1 -: ADDR_PERFIX];

  // Scan from the top down and restart the vector on every hit, so the
  // lowest matching index is the one left standing.
  always_comb begin
    hit_sel = '0;
    for (int k = SLAVE_NUM - 1; k >= 0; k--) begin
      if (prefix >= START_ADDRS[k*ADDR_PERFIX +: ADDR_PERFIX] &&
          prefix <  END_ADDRS[k*ADDR_PERFIX +: ADDR_PERFIX]) begin
        hit_sel    = '0;
        hit_sel[k] = 1'b1;
      end
    end
  end

  // sel_q is one-hot in ACCESS, so an OR-style mux is enough.
  always_comb begin
    slv_rdat = '0;
    for (int k = 0; k < SLAVE_NUM; k++)
      if (sel_q[k]) slv_rdat = s_dat_i[k*DW +: DW];
  end

  assign ack_hit     = |(s_ack_i & sel_q);
  assign err_hit     = |(s_err_i & sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rdat_d     = rdat_q;
    err_addr_d = err_addr_q;
    err_flag_d = err_flag_q;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          req_d   = '{we: m_we_i, adr: m_adr_i, dat: m_dat_i, sel: m_sel_i};
          sel_d   = hit_sel;
          cnt_d   = '0;
          state_d = (|hit_sel) ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + TW'(1);
        // A master that dropped cyc no longer wants any answer, so the abort
        // outranks whatever the slave says in the same cycle.
        if (!m_cyc_i)         state_d = IDLE;
        else if (err_hit)     state_d = ERR;
        else if (ack_hit) begin
          rdat_d  = slv_rdat;
          state_d = RESP;
        end
        else if (timeout_hit) state_d = ERR;
      end
      RESP: state_d = IDLE;
      ERR: begin
        err_addr_d = req_q.adr;
        err_flag_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (err_clr_i) err_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdat_q     <= '0;
      err_addr_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdat_q     <= rdat_d;
      err_addr_q <= err_addr_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign s_cyc_o    = (state_q == ACCESS) ? sel_q : '0;
  assign s_stb_o    = (state_q == ACCESS) ? sel_q : '0;
  assign m_ack_o    = (state_q == RESP);
  assign m_err_o    = (state_q == ERR);
  assign s_we_o     = req_q.we;
  assign s_adr_o    = req_q.adr;
  assign s_dat_o    = req_q.dat;
  assign s_sel_o    = req_q.sel;
  assign m_dat_o    = rdat_q;
  assign err_addr_o = err_addr_q;
  assign err_flag_o = err_flag_q;

endmodule

// File: tb/tb_wb_addr_decode_fsm.sv
// Bench for wb_addr_decode_fsm. Four windows: RAM 00-40, NOC 40-41, GPIO 41-42 and
// a wide slave3 30-50 overlapping RAM and NOC. Each slave returns its address
// XOR a per-slave tag as read data. Expected responses are queued when a request
// is driven and checked by a monitor when ack/err appears.
module tb_wb_addr_decode_fsm;
  localparam int NS = 4, AW = 32, DW = 32, SELW = 4, TO = 8;
  localparam logic [NS*8-1:0] ST = {8'h30, 8'h41, 8'h40, 8'h00};
  localparam logic [NS*8-1:0] EN = {8'h50, 8'h42, 8'h41, 8'h40};
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3, M_ABORT = 4;

  logic clk, reset;
  logic m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0] m_adr_i;
  logic [DW-1:0] m_dat_i, m_dat_o;
  logic [SELW-1:0] m_sel_i, s_sel_o;
  logic m_ack_o, m_err_o, s_we_o, err_flag_o, err_clr_i;
  logic [NS-1:0] s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [AW-1:0] s_adr_o, err_addr_o;
  logic [DW-1:0] s_dat_o;
  logic [NS*DW-1:0] s_dat_i;

  wb_addr_decode_fsm #(.SLAVE_NUM(NS), .ADDR_PERFIX(8), .AW(AW), .DW(DW),
    .START_ADDRS(ST), .END_ADDRS(EN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .err_addr_o(err_addr_o),
    .err_flag_o(err_flag_o), .err_clr_i(err_clr_i));

  typedef struct {
    int          kind;   // 0 ack, 1 err
    logic [31:0] data;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, cyc_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always_comb begin
    s_dat_i = '0;
    for (int k = 0; k < NS; k++) s_dat_i[k*DW +: DW] = s_adr_o ^ (32'hA500_0000 + 32'(k));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (m_ack_o || m_err_o)) begin
      if (sb.size() == 0) chk("spurious_resp", {m_ack_o, m_err_o}, 2'b00);
      else begin
        mon_e = sb.pop_front();
        chk("resp_kind", {m_ack_o, m_err_o}, (mon_e.kind == 0) ? 2'b10 : 2'b01);
        if (mon_e.kind == 0) chk("rdata", m_dat_o, mon_e.data);
        chk("latency", cyc_n - mon_e.t0, mon_e.lat);
      end
    end
  end

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                      input int waits, input int mode, input logic [NS-1:0] exp_sel,
                      input logic clr);
    exp_t e;
    int   idx = 0;
    logic got = 1'b0;
    logic want;
    for (int k = 0; k < NS; k++) if (exp_sel[k]) idx = k;
    want = (mode != M_ABORT);
    @(posedge clk); #1;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = wd; m_sel_i = 4'hF;
    if (want) begin
      e.t0   = cyc_n;
      e.data = adr ^ (32'hA500_0000 + 32'(idx));
      if (exp_sel == '0)      begin e.kind = 1; e.lat = 1; end
      else if (mode == M_NONE) begin e.kind = 1; e.lat = TO + 1; end
      else begin e.kind = (mode == M_ACK) ? 0 : 1; e.lat = waits + 2; end
      sb.push_back(e);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      s_ack_i = '0; s_err_i = '0;
      if (i == 0) begin
        chk("s_stb", s_stb_o, exp_sel);
        if (exp_sel != '0) begin
          chk("s_cyc", s_cyc_o, exp_sel);
          chk("s_req", {s_we_o, s_sel_o, s_adr_o, s_dat_o}, {we, 4'hF, adr, wd});
        end
      end
      if (m_ack_o || m_err_o) begin
        got = 1'b1;
        err_clr_i = clr;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        break;
      end
      if (mode == M_ABORT && i == waits) begin
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        break;
      end
      // Unselected slaves chatter every cycle; they must be ignored.
      s_ack_i = ~exp_sel;
      if (i == waits && (mode == M_ACK || mode == M_BOTH)) s_ack_i = s_ack_i | exp_sel;
      if (i == waits && (mode == M_ERR || mode == M_BOTH)) s_err_i = exp_sel;
    end
    @(posedge clk); #1;
    err_clr_i = 1'b0;
    s_ack_i = '0;
    chk("resp_seen", got, want);
    if (mode == M_ABORT) chk("abort_strobes", {s_cyc_o, s_stb_o}, '0);
    else if (exp_sel == '0 || mode != M_ACK) begin
      chk("err_addr", err_addr_o, adr);
      chk("err_flag", err_flag_o, !clr);
    end
  endtask

  task automatic clr_flag();
    @(posedge clk); #1 err_clr_i = 1'b1;
    @(posedge clk); #1 err_clr_i = 1'b0;
    chk("flag_cleared", err_flag_o, 1'b0);
  endtask

  initial begin
    reset = 1'b0; m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = '0; m_dat_i = '0;
    m_sel_i = '0; s_ack_i = '0; s_err_i = '0; err_clr_i = 0;
    #12;
    chk("rst_ctrl", {m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, err_flag_o}, '0);
    chk("rst_data", {s_adr_o, err_addr_o}, '0);
    @(negedge clk) reset = 1'b1;

    xfer(32'h3F00_0010, 1'b0, 32'h0,         2, M_ACK,  4'b0001, 1'b0); // RAM read, overlap with slave3
    xfer(32'h8012_3456, 1'b1, 32'h1111_2222, 0, M_ACK,  4'b0000, 1'b0); // no hit
    clr_flag();
    xfer(32'h4100_0020, 1'b0, 32'h0,         0, M_NONE, 4'b0100, 1'b0); // GPIO timeout
    xfer(32'h4500_0000, 1'b1, 32'hCAFE_F00D, 0, M_ACK,  4'b1000, 1'b0); // slave3 only
    xfer(32'h4000_0004, 1'b0, 32'h0,         1, M_ACK,  4'b0010, 1'b0); // NOC beats slave3
    xfer(32'h4FFF_FFFC, 1'b0, 32'h0,         3, M_ACK,  4'b1000, 1'b0); // last prefix in window
    xfer(32'h5000_0000, 1'b0, 32'h0,         0, M_ACK,  4'b0000, 1'b0); // exclusive end
    clr_flag();
    xfer(32'h4100_0000, 1'b0, 32'h0,         1, M_BOTH, 4'b0100, 1'b1); // err wins, clr wins
    xfer(32'h0000_0008, 1'b1, 32'h5555_AAAA, 1, M_ERR,  4'b0001, 1'b0); // slave error
    xfer(32'h2000_0000, 1'b0, 32'h0,         1, M_ABORT,4'b0001, 1'b0); // cyc dropped

    // Reset in the middle of an access clears everything.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_we_i = 1; m_adr_i = 32'h3F00_0100; m_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rstmid_stb", s_stb_o, 4'b0001);
    reset = 1'b0; #1;
    chk("rstmid_ctrl", {m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, err_flag_o}, '0);
    chk("rstmid_data", {s_adr_o, err_addr_o, m_dat_o, s_dat_o}, '0);
    m_cyc_i = 0; m_stb_i = 0;
    @(negedge clk) reset = 1'b1;
    xfer(32'h0000_0040, 1'b0, 32'h0, 0, M_ACK, 4'b0001, 1'b0);
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
endmodule
